irq_pend_arb4: RTL and testbench



---
 rtl/irq_arb_pkg.sv | 13 +
 rtl/prio_enc2_4to2.sv | 23 ++
 rtl/irq_pend_arb4.sv | 128 ++++++++++++
 tb/tb_irq_pend_arb4.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_arb_pkg.sv
// irq_arb_pkg: shared constants and FSM encoding for the request
// arbitration stage (irq_pend_arb4) and its priority encoder.
package irq_arb_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_t;

endpackage

// File: rtl/prio_enc2_4to2.sv
// prio_enc2_4to2: combinational 4-to-2 priority encoder, bit 3 highest.
//   in     [3:0]  request vector
//   id     [1:0]  index of the highest set bit (0 when none set)
//   valid         any bit of in set
module prio_enc2_4to2
    import irq_arb_pkg::*;
(
    input  logic [N_REQ-1:0] in,
    output logic [ID_W-1:0]  id,
    output logic             valid
);

    always_comb begin
        id = '0;
        if (in[3])      id = 2'd3;
        else if (in[2]) id = 2'd2;
        else if (in[1]) id = 2'd1;
        else            id = 2'd0;
    end

    assign valid = |in;

endmodule

// File: rtl/irq_pend_arb4.sv
// irq_pend_arb4: synchronises four async request lines, latches them into a
// pending register and offers the highest-priority unmasked pending bit as a
// 2-bit index over a valid/ready handshake.
//   clk, rst_n     clock, async active-low reset
//   req   [3:0]    async request lines (bit 3 highest priority)
//   mask  [3:0]    1 = excluded from arbitration (still latched)
//   irq_ready      consumer accepts the offered index
//   ovf_clr        clears the sticky overflow flag
//   irq_id [1:0]   registered offered index (holds last value when idle)
//   irq_valid      registered offer present
//   pend  [3:0]    registered pending bits
//   ovf            sticky: a request event hit an already-pending bit
// Build option: IRQ_PEND_EDGE_EN defined -> edge capture with overflow
// detection; undefined -> level capture, ovf tied low.
module irq_pend_arb4
    import irq_arb_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic             irq_ready,
    input  logic             ovf_clr,
    output logic [ID_W-1:0]  irq_id,
    output logic             irq_valid,
    output logic [N_REQ-1:0] pend,
    output logic             ovf
);

    logic [N_REQ-1:0] req_s;
    logic [N_REQ-1:0] set;
    logic [N_REQ-1:0] clr;
    logic [ID_W-1:0]  enc_id;
    logic             enc_valid;
    arb_state_t       state;

    // Synchroniser chain; stage 0 samples the raw async input.
    for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
        logic [N_REQ-1:0] q;
        if (g == 0) begin : g_first
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) q <= '0;
                else        q <= req;
            end
        end else begin : g_next
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) q <= '0;
                else        q <= g_sync[g-1].q;
            end
        end
    end
    assign req_s = g_sync[SYNC_STAGES-1].q;

    // Only the offered index can be cleared, and only on a handshake.
    always_comb begin
        clr = '0;
        if (irq_valid && irq_ready) clr[irq_id] = 1'b1;
    end

`ifdef IRQ_PEND_EDGE_EN
    logic [N_REQ-1:0] req_s_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_s_d <= '0;
        else        req_s_d <= req_s;
    end

    assign set = req_s & ~req_s_d;

    // Overflow: a fresh event on a bit that stays pending. Set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   ovf <= 1'b0;
        else if (|(set & pend & ~clr)) ovf <= 1'b1;
        else if (ovf_clr)             ovf <= 1'b0;
    end
`else
    logic unused_ovf_clr;

    assign set            = req_s;
    assign ovf            = 1'b0;
    assign unused_ovf_clr = ovf_clr;
`endif

    // Set wins over clear, so a held level request re-pends immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend <= '0;
        else        pend <= set | (pend & ~clr);
    end

    prio_enc2_4to2 u_enc (
        .in    (pend & ~mask),
        .id    (enc_id),
        .valid (enc_valid)
    );

    // Offer FSM: the offer is frozen until accepted, regardless of new
    // higher-priority arrivals or mask changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            irq_valid <= 1'b0;
            irq_id    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enc_valid) begin
                        irq_id    <= enc_id;
                        irq_valid <= 1'b1;
                        state     <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (irq_ready) begin
                        irq_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    irq_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_pend_arb4.sv
// tb_irq_pend_arb4: directed scenarios plus a randomized run checked against
// a cycle-level behavioural model of the arbitration stage.
module tb_irq_pend_arb4;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req, mask;
    logic       irq_ready, ovf_clr;
    logic [1:0] irq_id;
    logic       irq_valid;
    logic [3:0] pend;
    logic       ovf;

    int n_chk  = 0;
    int n_pass = 0;

    // behavioural model state
    logic [3:0] hist[$];   // hist[0] = req sampled at the most recent edge
    logic [3:0] m_pend;
    logic       m_valid;
    logic [1:0] m_id;
    logic       m_ovf;

`ifdef IRQ_PEND_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    irq_pend_arb4 #(.SYNC_STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mask      (mask),
        .irq_ready (irq_ready),
        .ovf_clr   (ovf_clr),
        .irq_id    (irq_id),
        .irq_valid (irq_valid),
        .pend      (pend),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i <= S; i++) hist.push_back(4'b0);
        m_pend  = '0;
        m_valid = 1'b0;
        m_id    = '0;
        m_ovf   = 1'b0;
    endtask

    // One clock: model consumes the inputs present at the edge; outputs
    // are then settled 1 time unit later.
    task automatic step();
        logic [3:0] rs, rsd, st, cl, elig;
        @(posedge clk);
        rs  = hist[S-1];
        rsd = hist[S];
        st  = EDGE ? (rs & ~rsd) : rs;
        cl  = (m_valid && irq_ready) ? (4'b0001 << m_id) : 4'b0000;
        if (EDGE) begin
            if ((st & m_pend & ~cl) != 0) m_ovf = 1'b1;
            else if (ovf_clr)             m_ovf = 1'b0;
        end
        if (m_valid) begin
            if (irq_ready) m_valid = 1'b0;
        end else begin
            elig = m_pend & ~mask;
            if (elig != 0) begin
                for (int i = 0; i < 4; i++) if (elig[i]) m_id = 2'(i);
                m_valid = 1'b1;
            end
        end
        m_pend = st | (m_pend & ~cl);
        hist.push_front(req);
        void'(hist.pop_back());
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; mask = '0; irq_ready = 1'b0; ovf_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (pend !== 4'b0) $display("FAIL reset_pend got %b want 0000", pend); else n_pass++;
        n_chk++; if (irq_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", irq_valid); else n_pass++;
        n_chk++; if (irq_id !== 2'b0) $display("FAIL reset_id got %0d want 0", irq_id); else n_pass++;
        n_chk++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        irq_ready = 1'b1;
        req = 4'b0100; step();
        req = 4'b0000; step(); step();
        n_chk++; if (pend !== 4'b0100) $display("FAIL single_pend got %b want 0100", pend); else n_pass++;
        n_chk++; if (irq_valid !== 1'b0) $display("FAIL single_early_valid got %b want 0", irq_valid); else n_pass++;
        step();
        n_chk++; if (irq_valid !== 1'b1 || irq_id !== 2'd2)
            $display("FAIL single_offer got v=%b id=%0d want v=1 id=2", irq_valid, irq_id); else n_pass++;
        step();
        n_chk++; if (irq_valid !== 1'b0 || pend !== 4'b0)
            $display("FAIL single_accept got v=%b pend=%b want v=0 pend=0000", irq_valid, pend); else n_pass++;
    endtask

    task automatic test_all_four();
        int ids[$];
        int cyc[$];
        irq_ready = 1'b1;
        req = 4'b1111; step();
        req = 4'b0000;
        for (int c = 0; c < 30; c++) begin
            step();
            if (irq_valid) begin
                ids.push_back(int'(irq_id));
                cyc.push_back(c);
            end
        end
        n_chk++; if (ids.size() != 4) $display("FAIL four_count got %0d want 4", ids.size()); else n_pass++;
        for (int i = 0; i < 4 && i < ids.size(); i++) begin
            n_chk++; if (ids[i] != 3 - i) $display("FAIL four_order[%0d] got %0d want %0d", i, ids[i], 3 - i); else n_pass++;
        end
        for (int i = 1; i < cyc.size(); i++) begin
            n_chk++; if (cyc[i] - cyc[i-1] != 2) $display("FAIL four_gap[%0d] got %0d want 2", i, cyc[i] - cyc[i-1]); else n_pass++;
        end
        n_chk++; if (irq_valid !== 1'b0 || pend !== 4'b0)
            $display("FAIL four_drain got v=%b pend=%b want v=0 pend=0000", irq_valid, pend); else n_pass++;
    endtask

    task automatic test_hold_offer();
        int t;
        bit bad;
        irq_ready = 1'b0;
        req = 4'b0010; step();
        req = 4'b0000;
        t = 0;
        while (!irq_valid && t < 10) begin step(); t++; end
        n_chk++; if (irq_valid !== 1'b1 || irq_id !== 2'd1)
            $display("FAIL hold_first got v=%b id=%0d want v=1 id=1", irq_valid, irq_id); else n_pass++;
        req = 4'b1000; step();
        req = 4'b0000;
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (irq_valid !== 1'b1 || irq_id !== 2'd1) bad = 1'b1;
        end
        n_chk++; if (bad) $display("FAIL hold_stable got v=%b id=%0d want v=1 id=1", irq_valid, irq_id); else n_pass++;
        n_chk++; if (pend !== 4'b1010) $display("FAIL hold_pend got %b want 1010", pend); else n_pass++;
        irq_ready = 1'b1; step();
        irq_ready = 1'b0; step();
        n_chk++; if (irq_valid !== 1'b1 || irq_id !== 2'd3)
            $display("FAIL hold_next got v=%b id=%0d want v=1 id=3", irq_valid, irq_id); else n_pass++;
        irq_ready = 1'b1; step(); step();
    endtask

    task automatic test_mask();
        int t;
        irq_ready = 1'b1;
        mask = 4'b1000;
        req = 4'b1001; step();
        req = 4'b0000;
        t = 0;
        while (!irq_valid && t < 10) begin step(); t++; end
        n_chk++; if (irq_valid !== 1'b1 || irq_id !== 2'd0)
            $display("FAIL mask_offer got v=%b id=%0d want v=1 id=0", irq_valid, irq_id); else n_pass++;
        repeat (6) step();
        n_chk++; if (irq_valid !== 1'b0 || pend !== 4'b1000)
            $display("FAIL mask_parked got v=%b pend=%b want v=0 pend=1000", irq_valid, pend); else n_pass++;
        mask = 4'b0000; step();
        n_chk++; if (irq_valid !== 1'b1 || irq_id !== 2'd3)
            $display("FAIL mask_release got v=%b id=%0d want v=1 id=3", irq_valid, irq_id); else n_pass++;
        step(); step();
    endtask

    task automatic test_ovf();
`ifdef IRQ_PEND_EDGE_EN
        irq_ready = 1'b0;
        req = 4'b0100; step();
        req = 4'b0000; repeat (4) step();
        n_chk++; if (ovf !== 1'b0) $display("FAIL ovf_first got %b want 0", ovf); else n_pass++;
        req = 4'b0100; step();
        req = 4'b0000; repeat (4) step();
        n_chk++; if (ovf !== 1'b1 || pend[2] !== 1'b1)
            $display("FAIL ovf_set got ovf=%b pend=%b want ovf=1 pend[2]=1", ovf, pend); else n_pass++;
        ovf_clr = 1'b1; step();
        ovf_clr = 1'b0;
        n_chk++; if (ovf !== 1'b0) $display("FAIL ovf_clear got %b want 0", ovf); else n_pass++;
        irq_ready = 1'b1; repeat (3) step();
`else
        int offers;
        bit ovf_seen;
        irq_ready = 1'b1;
        req = 4'b0100;
        offers = 0; ovf_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (irq_valid && irq_id == 2'd2) offers++;
            if (ovf !== 1'b0) ovf_seen = 1'b1;
        end
        n_chk++; if (offers < 7) $display("FAIL level_reoffer got %0d offers want >=7", offers); else n_pass++;
        n_chk++; if (ovf_seen) $display("FAIL level_ovf got 1 want 0"); else n_pass++;
        req = 4'b0000; repeat (6) step();
`endif
    endtask

    task automatic test_async_reset();
        int t;
        bit bad;
        irq_ready = 1'b0;
        req = 4'b0001; step();
        req = 4'b0000;
        t = 0;
        while (!irq_valid && t < 10) begin step(); t++; end
        n_chk++; if (irq_valid !== 1'b1) $display("FAIL areset_pre got v=%b want 1", irq_valid); else n_pass++;
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_chk++; if (irq_valid !== 1'b0 || pend !== 4'b0 || ovf !== 1'b0)
            $display("FAIL areset_now got v=%b pend=%b ovf=%b want 0/0000/0", irq_valid, pend, ovf); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (irq_valid !== 1'b0) bad = 1'b1;
        end
        n_chk++; if (bad) $display("FAIL areset_quiet got v=1 want 0"); else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            req       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            if ($urandom_range(0, 15) == 0) mask = 4'($urandom) & 4'($urandom);
            irq_ready = 1'($urandom);
            ovf_clr   = ($urandom_range(0, 9) == 0);
            step();
            n_chk++; if (pend !== m_pend) $display("FAIL rnd_pend c=%0d got %b want %b", c, pend, m_pend); else n_pass++;
            n_chk++; if (irq_valid !== m_valid) $display("FAIL rnd_valid c=%0d got %b want %b", c, irq_valid, m_valid); else n_pass++;
            n_chk++; if (irq_id !== m_id) $display("FAIL rnd_id c=%0d got %0d want %0d", c, irq_id, m_id); else n_pass++;
            n_chk++; if (ovf !== m_ovf) $display("FAIL rnd_ovf c=%0d got %b want %b", c, ovf, m_ovf); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_hold_offer();
        test_mask();
        test_ovf();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
